// File: rtl/cache_line_xfer_engine.sv
// rtl/cache_line_xfer_engine.sv - moves one cache line between the data array and the memory-side streams
module cache_line_xfer_engine #(
  parameter int DATA_W         = 32,
  parameter int INDEX_W        = 10,
  parameter int WORDS_PER_LINE = 4,
  parameter int OFF_W          = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_op_i,
  input  logic [INDEX_W-OFF_W-1:0] req_line_i,
  output logic                     done_o,
  output logic [INDEX_W-1:0]       arr_index_o,
  output logic [DATA_W-1:0]        arr_wdata_o,
  output logic                     arr_we_o,
  input  logic [DATA_W-1:0]        arr_rdata_i,
  input  logic                     mem_rvalid_i,
  output logic                     mem_rready_o,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     mem_wvalid_o,
  input  logic                     mem_wready_i,
  output logic [DATA_W-1:0]        mem_wdata_o
);

  localparam int LINE_W = INDEX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WB, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt is exactly OFF_W bits wide, so the increment on the last word wraps it to 0
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          line_d  = req_line_i;
          cnt_d   = '0;
          state_d = req_op_i ? S_WB : S_FILL;
        end
      end
      S_FILL: begin
        if (mem_rvalid_i) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_CNT) state_d = S_DONE;
        end
      end
      S_WB: begin
        if (mem_wready_i) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_CNT) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    done_o       = 1'b0;
    arr_we_o     = 1'b0;
    mem_rready_o = 1'b0;
    mem_wvalid_o = 1'b0;
    arr_index_o  = {line_q, cnt_q};
    arr_wdata_o  = mem_rdata_i;
    mem_wdata_o  = arr_rdata_i;
    unique case (state_q)
      S_IDLE: req_ready_o = 1'b1;
      S_FILL: begin
        mem_rready_o = 1'b1;
        arr_we_o     = mem_rvalid_i;
      end
      S_WB:   mem_wvalid_o = 1'b1;
      S_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_line_xfer_engine.sv
// tb/tb_cache_line_xfer_engine.sv - directed vector bench for cache_line_xfer_engine
module tb_cache_line_xfer_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [7:0]  req_line = '0;
  logic        done;
  logic [9:0]  arr_index;
  logic [31:0] arr_wdata;
  logic        arr_we;
  logic [31:0] arr_rdata;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic [31:0] mem_rdata = '0;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic init_mem = 1'b1;
  logic [31:0] amem [1024];

  always #5 clk = ~clk;

  cache_line_xfer_engine dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op), .req_line_i(req_line),
    .done_o(done),
    .arr_index_o(arr_index), .arr_wdata_o(arr_wdata), .arr_we_o(arr_we), .arr_rdata_i(arr_rdata),
    .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready), .mem_rdata_i(mem_rdata),
    .mem_wvalid_o(mem_wvalid), .mem_wready_i(mem_wready), .mem_wdata_o(mem_wdata)
  );

  // Async-read data array model
  assign arr_rdata = amem[arr_index];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) amem[i] <= 32'h0BAD0000 | 32'(i);
      for (int i = 0; i < 4; i++) amem[40+i] <= 32'hB0 + 32'(i);
    end else if (arr_we) begin
      amem[arr_index] <= arr_wdata;
    end
    if (mem_wvalid && mem_wready) hs_cnt <= hs_cnt + 1;
  end

  typedef struct {
    logic rq; logic op; logic [7:0] ln; logic rv; logic [31:0] rd; logic wr;
    logic e_ready; logic e_done; logic e_we; logic e_rready; logic e_wvalid;
    logic [9:0] e_idx; logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rq, input logic op, input logic [7:0] ln, input logic rv,
                             input logic [31:0] rd, input logic wr, input logic e_ready,
                             input logic e_done, input logic e_we, input logic e_rready,
                             input logic e_wvalid, input logic [9:0] e_idx, input logic [31:0] e_data);
    vec_t t;
    t.rq = rq; t.op = op; t.ln = ln; t.rv = rv; t.rd = rd; t.wr = wr;
    t.e_ready = e_ready; t.e_done = e_done; t.e_we = e_we; t.e_rready = e_rready;
    t.e_wvalid = e_wvalid; t.e_idx = e_idx; t.e_data = e_data;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rq, input logic op, input logic [7:0] ln, input logic rv,
                       input logic [31:0] rd, input logic wr);
    @(negedge clk);
    req_valid = rq; req_op = op; req_line = ln;
    mem_rvalid = rv; mem_rdata = rd; mem_wready = wr;
    #1;
  endtask

  task automatic chk_state(input string nm, input logic e_ready, input logic e_done,
                           input logic e_we, input logic e_rready, input logic e_wvalid,
                           input logic [9:0] e_idx);
    chk({nm, " req_ready"}, 32'(req_ready), 32'(e_ready));
    chk({nm, " done"}, 32'(done), 32'(e_done));
    chk({nm, " arr_we"}, 32'(arr_we), 32'(e_we));
    chk({nm, " mem_rready"}, 32'(mem_rready), 32'(e_rready));
    chk({nm, " mem_wvalid"}, 32'(mem_wvalid), 32'(e_wvalid));
    chk({nm, " arr_index"}, 32'(arr_index), 32'(e_idx));
  endtask

  initial begin
    // test 1: fill line 5 (indices 20..23), rvalid continuous
    vecs.push_back(v(1,0,5, 0,0,1,       1,0,0,0,0, 10'd0,  0));
    vecs.push_back(v(0,0,0, 1,32'hA0,0,  0,0,1,1,0, 10'd20, 32'hA0));
    vecs.push_back(v(0,0,0, 1,32'hA1,0,  0,0,1,1,0, 10'd21, 32'hA1));
    vecs.push_back(v(0,0,0, 1,32'hA2,0,  0,0,1,1,0, 10'd22, 32'hA2));
    vecs.push_back(v(0,0,0, 1,32'hA3,0,  0,0,1,1,0, 10'd23, 32'hA3));
    vecs.push_back(v(0,0,0, 1,32'hFF,0,  0,1,0,0,0, 10'd20, 0));
    vecs.push_back(v(0,0,0, 0,0,0,       1,0,0,0,0, 10'd20, 0));
    // test 2: writeback line 10 (indices 40..43), wready 1,0,0,1,1,0,1
    vecs.push_back(v(1,1,10, 1,0,0,      1,0,0,0,0, 10'd20, 0));
    vecs.push_back(v(0,0,0, 1,0,1,       0,0,0,0,1, 10'd40, 32'hB0));
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,1, 10'd41, 32'hB1));
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,1, 10'd41, 32'hB1));
    vecs.push_back(v(0,0,0, 0,0,1,       0,0,0,0,1, 10'd41, 32'hB1));
    vecs.push_back(v(0,0,0, 0,0,1,       0,0,0,0,1, 10'd42, 32'hB2));
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,1, 10'd43, 32'hB3));
    vecs.push_back(v(0,0,0, 0,0,1,       0,0,0,0,1, 10'd43, 32'hB3));
    vecs.push_back(v(0,0,0, 0,0,1,       0,1,0,0,0, 10'd40, 0));
    vecs.push_back(v(0,0,0, 0,0,1,       1,0,0,0,0, 10'd40, 0));
    // test 3: fill line 2 (indices 8..11), rvalid 1,0,1,0,1,1
    vecs.push_back(v(1,0,2, 0,0,0,       1,0,0,0,0, 10'd40, 0));
    vecs.push_back(v(0,0,0, 1,32'hC0,0,  0,0,1,1,0, 10'd8,  32'hC0));
    vecs.push_back(v(0,0,0, 0,32'hEE,0,  0,0,0,1,0, 10'd9,  0));
    vecs.push_back(v(0,0,0, 1,32'hC1,0,  0,0,1,1,0, 10'd9,  32'hC1));
    vecs.push_back(v(0,0,0, 0,32'hEE,0,  0,0,0,1,0, 10'd10, 0));
    vecs.push_back(v(0,0,0, 1,32'hC2,0,  0,0,1,1,0, 10'd10, 32'hC2));
    vecs.push_back(v(0,0,0, 1,32'hC3,0,  0,0,1,1,0, 10'd11, 32'hC3));
    vecs.push_back(v(0,0,0, 0,0,0,       0,1,0,0,0, 10'd8,  0));
    vecs.push_back(v(0,0,0, 0,0,0,       1,0,0,0,0, 10'd8,  0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_state("reset", 1, 0, 0, 0, 0, 10'd0);
    rst = 1'b0;
    init_mem = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rq, vecs[i].op, vecs[i].ln, vecs[i].rv, vecs[i].rd, vecs[i].wr);
      chk_state($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_done, vecs[i].e_we,
                vecs[i].e_rready, vecs[i].e_wvalid, vecs[i].e_idx);
      if (vecs[i].e_we) chk($sformatf("row%0d arr_wdata", i), arr_wdata, vecs[i].e_data);
      if (vecs[i].e_wvalid) chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_data);
    end
    chk("wb handshakes", 32'(hs_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("line5 word%0d", i), amem[20+i], 32'hA0 + 32'(i));
      chk($sformatf("line2 word%0d", i), amem[8+i], 32'hC0 + 32'(i));
    end

    // test 4: second request (line 7) held during fill of line 3
    drive(1,0,3, 0,0,0);
    chk_state("t4 accept", 1, 0, 0, 0, 0, 10'd8);
    for (int c = 1; c <= 4; c++) begin
      drive(1,0,7, 1,32'hD0 + 32'(c),0);
      chk_state($sformatf("t4 c%0d", c), 0, 0, 1, 1, 0, 10'(12 + c - 1));
    end
    drive(1,0,7, 1,0,0);
    chk_state("t4 done", 0, 1, 0, 0, 0, 10'd12);
    drive(1,0,7, 0,0,0);
    chk_state("t4 idle", 1, 0, 0, 0, 0, 10'd12);
    for (int c = 0; c < 4; c++) begin
      drive(0,0,0, 1,32'hD8 + 32'(c),0);
      chk_state($sformatf("t4 line7 c%0d", c), 0, 0, 1, 1, 0, 10'(28 + c));
    end
    drive(0,0,0, 0,0,0);
    chk_state("t4 line7 done", 0, 1, 0, 0, 0, 10'd28);
    drive(0,0,0, 0,0,0);
    chk("t4 line3 word3", amem[15], 32'hD4);
    chk("t4 line7 word0", amem[28], 32'hD8);

    // test 5: async reset after two fill words of line 1
    drive(1,0,1, 0,0,0);
    drive(0,0,0, 1,32'h51,0);
    drive(0,0,0, 1,32'h52,0);
    drive(0,0,0, 1,32'h53,0);
    chk_state("t5 pre-rst", 0, 0, 1, 1, 0, 10'd6);
    rst = 1'b1;
    #1;
    chk_state("t5 in-rst", 1, 0, 0, 0, 0, 10'd0);
    drive(0,0,0, 1,32'h54,1);
    rst = 1'b0;
    #1;
    chk_state("t5 post-rst", 1, 0, 0, 0, 0, 10'd0);
    drive(0,0,0, 0,0,0);
    chk("t5 no done", 32'(done), 32'd0);
    chk("t5 word0", amem[4], 32'h51);
    chk("t5 word1", amem[5], 32'h52);
    chk("t5 word2", amem[6], 32'h0BAD0006);
    chk("t5 word3", amem[7], 32'h0BAD0007);

    // test 6: top line 255 (indices 1020..1023)
    drive(1,0,255, 0,0,0);
    for (int c = 0; c < 4; c++) begin
      drive(0,0,0, 1,32'hE0 + 32'(c),0);
      chk_state($sformatf("t6 fill c%0d", c), 0, 0, 1, 1, 0, 10'(1020 + c));
    end
    drive(0,0,0, 0,0,0);
    chk_state("t6 fill done", 0, 1, 0, 0, 0, 10'd1020);
    drive(1,1,255, 0,0,0);
    chk_state("t6 wb accept", 1, 0, 0, 0, 0, 10'd1020);
    for (int c = 0; c < 4; c++) begin
      drive(0,0,0, 0,0,1);
      chk_state($sformatf("t6 wb c%0d", c), 0, 0, 0, 0, 1, 10'(1020 + c));
      chk($sformatf("t6 wb data%0d", c), mem_wdata, 32'hE0 + 32'(c));
    end
    drive(0,0,0, 0,0,0);
    chk_state("t6 wb done", 0, 1, 0, 0, 0, 10'd1020);
    chk("t6 index0 untouched", amem[0], 32'h0BAD0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
